// File: rtl/cacheline_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a single cacheline adaptor.
// Round-robin under contention, one transaction at a time, all outputs registered.
module cacheline_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_read,
  output logic              m_write,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic [LINE_W-1:0] m_wdata_q, m_wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;
  logic              d_req, grant_d;

  assign d_req = d_read | d_write;

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    m_addr_d  = m_addr_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_resp_d  = 1'b0;
    d_resp_d  = 1'b0;
    grant_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // under contention D wins unless D was the last port served
        grant_d = d_req & (~i_read | ~last_d_q);
        if (grant_d) begin
          state_d   = SERVE_D;
          m_addr_d  = d_addr;
          m_write_d = d_write;
          m_read_d  = ~d_write;
          if (d_write) m_wdata_d = d_wdata;
        end else if (i_read) begin
          state_d   = SERVE_I;
          m_addr_d  = i_addr;
          m_read_d  = 1'b1;
          m_write_d = 1'b0;
        end
      end
      SERVE_I: begin
        if (m_resp) begin
          state_d   = RELEASE;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          i_rdata_d = m_rdata;
          i_resp_d  = 1'b1;
          last_d_d  = 1'b0;
        end
      end
      SERVE_D: begin
        if (m_resp) begin
          state_d   = RELEASE;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          if (m_read_q) d_rdata_d = m_rdata;
          d_resp_d  = 1'b1;
          last_d_d  = 1'b1;
        end
      end
      // one dead cycle lets the served cache drop its request before re-arbitration
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      m_addr_q  <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      m_addr_q  <= m_addr_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_resp_q  <= i_resp_d;
      d_resp_q  <= d_resp_d;
    end
  end

  assign m_addr  = m_addr_q;
  assign m_read  = m_read_q;
  assign m_write = m_write_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_resp  = i_resp_q;
  assign d_resp  = d_resp_q;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: cache/adaptor models plus a transaction-level
// reference that predicts grant order, adaptor requests and returned lines.
module tb_cacheline_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  typedef logic [LINE_W-1:0] line_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] i_addr, d_addr, m_addr;
  logic              i_read, i_resp, d_read, d_write, d_resp;
  logic              m_read, m_write, m_resp;
  line_t             i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;

  always #5 clk = ~clk;

  cacheline_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_resp(m_resp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // cache-side request state (0 = I, 1 = D for owners / last grant)
  bit              i_pend, d_pend, d_rd, d_wr;
  logic [ADDR_W-1:0] i_a, d_a;
  line_t           d_wd;
  // reference state
  int              last_g, owner, dly, gap, fix_delay;
  bit              act, cur_wr, rnd_en, stray, reraise, rd_fixed;
  logic [ADDR_W-1:0] cur_addr;
  line_t           cur_wd, given, rd_val, exp_i_data, exp_d_data;
  int              grants[$];
  int              gaps[$];
  int              mread_cycles;

  task automatic chk(input string tag, input line_t got, input line_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int k = 0; k < LINE_W/32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic drive_in();
    i_read  = i_pend;
    i_addr  = i_a;
    d_read  = d_pend & d_rd;
    d_write = d_pend & d_wr;
    d_addr  = d_a;
    d_wdata = d_wd;
  endtask

  task automatic observe();
    bit ei, ed, m_act;
    int eo;
    ei = 0; ed = 0;
    if (act && m_resp) begin
      if (owner == 0) ei = 1; else ed = 1;
      act = 0; gap = 0;
    end
    m_resp = 1'b0;
    m_act = m_read | m_write;
    if (m_read) mread_cycles++;
    chk("excl", line_t'(m_read & m_write), '0);
    chk("i_resp", line_t'(i_resp), line_t'(ei));
    chk("d_resp", line_t'(d_resp), line_t'(ed));
    if (ei) begin exp_i_data = given; i_pend = 0; last_g = 0; end
    if (ed) begin if (!cur_wr) exp_d_data = given; d_pend = 0; last_g = 1; end
    chk("i_rdata", i_rdata, exp_i_data);
    chk("d_rdata", d_rdata, exp_d_data);
    if (!act && m_act) begin
      chk("grant_pending", line_t'(i_pend | d_pend), 1);
      chk("gap_min2", line_t'(gap >= 2), 1);
      eo = (i_pend && d_pend) ? (last_g == 0 ? 1 : 0) : (d_pend ? 1 : 0);
      cur_wr   = (eo == 1) && d_wr;
      cur_addr = (eo == 1) ? d_a : i_a;
      cur_wd   = d_wd;
      chk("m_addr", line_t'(m_addr), line_t'(cur_addr));
      chk("m_op", line_t'({m_read, m_write}), line_t'({!cur_wr, cur_wr}));
      if (cur_wr) chk("m_wdata", m_wdata, cur_wd);
      owner = eo;
      grants.push_back(eo);
      gaps.push_back(gap);
      act = 1;
      dly = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 5));
    end else if (act) begin
      chk("hold_op", line_t'({m_read, m_write}), line_t'({!cur_wr, cur_wr}));
      chk("hold_addr", line_t'(m_addr), line_t'(cur_addr));
      if (cur_wr) chk("hold_wdata", m_wdata, cur_wd);
    end
    if (!act) gap++;
    // adaptor model
    if (act) begin
      if (dly == 0) begin
        given   = rd_fixed ? rd_val : rand_line();
        m_rdata = given;
        m_resp  = 1'b1;
      end else dly--;
    end else if (stray && ($urandom % 3 == 0)) begin
      m_rdata = rand_line();
      m_resp  = 1'b1;
    end
  endtask

  task automatic tick();
    int r;
    @(posedge clk); #1;
    observe();
    if (reraise) begin
      if (!i_pend) begin i_pend = 1; i_a = $urandom; end
      if (!d_pend) begin d_pend = 1; d_rd = 1; d_wr = 0; d_a = $urandom; end
    end
    if (rnd_en) begin
      if (!i_pend && ($urandom % 3 == 0)) begin i_pend = 1; i_a = $urandom; end
      if (!d_pend && ($urandom % 3 == 0)) begin
        d_pend = 1; d_a = $urandom; d_wd = rand_line();
        r = int'($urandom % 8);
        d_wr = (r < 3) || (r == 7);
        d_rd = (r >= 3);
      end
    end
    drive_in();
  endtask

  task automatic do_reset();
    reset = 1'b1; m_resp = 1'b0;
    i_pend = 0; d_pend = 0; drive_in();
    @(posedge clk); #1;
    last_g = 0; act = 0; gap = 2; exp_i_data = '0; exp_d_data = '0;
    reset = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    do begin tick(); k++; end while ((i_pend || d_pend || act) && k < budget);
    chk("wait_bound", line_t'(k < budget), 1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_m_read"}, line_t'(m_read), '0);
    chk({tag, "_m_write"}, line_t'(m_write), '0);
    chk({tag, "_m_addr"}, line_t'(m_addr), '0);
    chk({tag, "_m_wdata"}, m_wdata, '0);
    chk({tag, "_resp"}, line_t'({i_resp, d_resp}), '0);
    chk({tag, "_i_rdata"}, i_rdata, '0);
    chk({tag, "_d_rdata"}, d_rdata, '0);
  endtask

  initial begin
    int k;
    i_a = '0; d_a = '0; d_wd = '0; d_rd = 0; d_wr = 0; m_rdata = '0;
    fix_delay = -1; rnd_en = 0; stray = 0; reraise = 0; rd_fixed = 0;
    rd_val = '0; given = '0; owner = 0; dly = 0; cur_wr = 0; cur_addr = '0; cur_wd = '0;
    mread_cycles = 0;
    do_reset();
    chk_reset_state("rst");

    // lone I read, adaptor answers after 6 cycles
    rd_fixed = 1; rd_val = {32{8'hA5}}; fix_delay = 6;
    i_pend = 1; i_a = 32'h0000_1000; drive_in();
    wait_done(60);
    chk("t1_i_rdata", i_rdata, {32{8'hA5}});
    chk("t1_grant_i", line_t'(grants[$]), 0);

    // lone D writeback: d_rdata must stay at its reset value
    fix_delay = 3; rd_val = rand_line();
    d_pend = 1; d_rd = 0; d_wr = 1; d_a = 32'h0000_2040;
    d_wd = {2{128'h00112233445566778899AABBCCDDEEFF}}; drive_in();
    wait_done(60);
    chk("t2_d_rdata_kept", d_rdata, '0);
    chk("t2_grant_d", line_t'(grants[$]), 1);

    // contention right after reset, both caches re-requesting continuously
    do_reset();
    grants.delete(); gaps.delete();
    fix_delay = -1; rd_fixed = 0; reraise = 1;
    i_pend = 1; i_a = $urandom; d_pend = 1; d_rd = 1; d_wr = 0; d_a = $urandom; drive_in();
    k = 0;
    while (grants.size() < 4 && k < 200) begin tick(); k++; end
    chk("t3_bound", line_t'(grants.size() >= 4), 1);
    if (grants.size() >= 4) begin
      chk("t3_order", line_t'({grants[0][1:0], grants[1][1:0], grants[2][1:0], grants[3][1:0]}),
          line_t'({2'd1, 2'd0, 2'd1, 2'd0}));
      for (int g = 1; g < 4; g++) chk("t3_gap2", line_t'(gaps[g]), 2);
    end
    reraise = 0;
    wait_done(100);

    // read+write together collapses to one write
    mread_cycles = 0;
    k = grants.size();
    d_pend = 1; d_rd = 1; d_wr = 1; d_a = $urandom; d_wd = rand_line(); drive_in();
    wait_done(60);
    chk("t4_one_txn", line_t'(grants.size() - k), 1);
    chk("t4_no_mread", line_t'(mread_cycles), 0);

    // reset three cycles into a D read aborts it silently
    fix_delay = 20;
    d_pend = 1; d_rd = 1; d_wr = 0; d_a = $urandom; drive_in();
    k = 0;
    while (!act && k < 20) begin tick(); k++; end
    chk("t5_started", line_t'(act), 1);
    tick(); tick();
    do_reset();
    chk_reset_state("t5");
    fix_delay = -1;
    i_pend = 1; i_a = 32'h0000_3000; drive_in();
    wait_done(60);
    chk("t5_fresh_i", line_t'(grants[$]), 0);
    chk("t5_fresh_data", i_rdata, given);

    // random traffic with stray adaptor pulses while idle
    rnd_en = 1; stray = 1;
    for (int c = 0; c < 3000; c++) tick();
    rnd_en = 0; stray = 0;
    wait_done(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
